// File: rtl/ita_tile_streamer_if.sv
// Purpose : bundles the memory read request/response channel and the beat
//           stream towards the ITA controller into one port.
// Ports   : req_* (read request), rsp_* (in-order read data), oup_* (beats
//           plus first/last inner-tile tags). Suffixes are from the streamer's view.
interface ita_tile_streamer_if #(
    parameter int AddrW = 32,
    parameter int DataW = 128
) ();
    logic             req_valid_o;
    logic             req_ready_i;
    logic [AddrW-1:0] req_addr_o;
    logic             rsp_valid_i;
    logic [DataW-1:0] rsp_data_i;
    logic             oup_valid_o;
    logic             oup_ready_i;
    logic [DataW-1:0] oup_data_o;
    logic             first_inner_tile_o;
    logic             last_inner_tile_o;

    // streamer side
    modport master (
        output req_valid_o, req_addr_o, oup_valid_o, oup_data_o,
               first_inner_tile_o, last_inner_tile_o,
        input  req_ready_i, rsp_valid_i, rsp_data_i, oup_ready_i
    );

    // memory + controller side
    modport slave (
        input  req_valid_o, req_addr_o, oup_valid_o, oup_data_o,
               first_inner_tile_o, last_inner_tile_o,
        output req_ready_i, rsp_valid_i, rsp_data_i, oup_ready_i
    );
endinterface

// File: rtl/ita_tile_streamer.sv
// Purpose : walks outer tile / inner tile / beat of a Linear step, issues
//           sequential reads and streams in-order responses as tagged beats.
// Latency : response to beat-valid is 1 cycle (FIFO head registered).
// Backpressure: credits = FifoDepth; requests stall once outstanding + buffered
//           reaches FifoDepth, so the response path never needs to push back.
// Ports   : clk_i/rst_i (sync, active-high), start_i + tile counts + base_addr_i
//           job setup, busy_o/done_o status, bus = request/response/beat channels.
module ita_tile_streamer #(
    parameter int M         = 64,
    parameter int N         = 16,
    parameter int DataW     = 128,
    parameter int AddrW     = 32,
    parameter int TileW     = 8,
    parameter int FifoDepth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [TileW-1:0] tile_s_i,
    input  logic [TileW-1:0] tile_p_i,
    input  logic [TileW-1:0] tile_e_i,
    input  logic [AddrW-1:0] base_addr_i,
    output logic             busy_o,
    output logic             done_o,
    ita_tile_streamer_if.master bus
);
    localparam int BeatsPerTile = M * M / N;
    localparam int BytesPerBeat = DataW / 8;
    localparam int BeatW        = (BeatsPerTile > 1) ? $clog2(BeatsPerTile) : 1;
    localparam int TotW         = 3 * TileW + BeatW + 1;
    localparam int PtrW         = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW         = $clog2(FifoDepth + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [TotW-1:0]    total_q, total_d;
    logic [TotW-1:0]    req_idx_q, req_idx_d;
    logic [TotW-1:0]    tile_q, tile_d;
    logic [TileW-1:0]   tile_e_q, tile_e_d;
    logic [TileW-1:0]   inner_q, inner_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [CntW-1:0]    outst_q, outst_d;
    logic [CntW-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic               zero_done_q, zero_done_d;
    logic [DataW-1:0]   mem_q [FifoDepth];

    logic accept, push, pop, last_req, last_pop, credit_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Registered counts only: a pop frees its credit one cycle later.
    assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < (CntW + 1)'(FifoDepth);
    assign accept    = bus.req_valid_o && bus.req_ready_i;
    // A response with nothing outstanding is dropped rather than corrupting the FIFO.
    assign push      = bus.rsp_valid_i && (outst_q != '0);
    assign pop       = bus.oup_valid_o && bus.oup_ready_i;
    assign last_req  = (req_idx_q == total_q - TotW'(1));
    // In Drain every request has been issued, so the final pop empties everything.
    assign last_pop  = pop && (fifo_cnt_q == CntW'(1)) && (outst_q == '0);

    assign bus.req_valid_o        = (state_q == RUN) && credit_ok;
    assign bus.req_addr_o         = addr_q;
    assign bus.oup_valid_o        = (fifo_cnt_q != '0);
    assign bus.oup_data_o         = mem_q[rd_ptr_q];
    assign bus.first_inner_tile_o = bus.oup_valid_o && (inner_q == '0);
    assign bus.last_inner_tile_o  = bus.oup_valid_o && (inner_q == tile_e_q - 1'b1);
    assign busy_o                 = (state_q != IDLE);
    assign done_o                 = zero_done_q || ((state_q == DRAIN) && last_pop);

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        req_idx_d   = req_idx_q;
        tile_d      = tile_q;
        tile_e_d    = tile_e_q;
        inner_d     = inner_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        zero_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    total_d   = TotW'(tile_s_i) * TotW'(tile_p_i) * TotW'(tile_e_i)
                              * TotW'(BeatsPerTile);
                    tile_e_d  = tile_e_i;
                    addr_d    = base_addr_i;
                    req_idx_d = '0;
                    tile_d    = '0;
                    inner_d   = '0;
                    beat_d    = '0;
                    if (tile_s_i == '0 || tile_p_i == '0 || tile_e_i == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN:     if (accept && last_req) state_d = DRAIN;
            DRAIN:   if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            addr_d    = addr_q + AddrW'(BytesPerBeat);
            req_idx_d = req_idx_q + 1'b1;
        end
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (beat_q == BeatW'(BeatsPerTile - 1)) begin
                beat_d = '0;
                if (inner_q == tile_e_q - 1'b1) begin
                    inner_d = '0;
                    tile_d  = tile_q + 1'b1;
                end else begin
                    inner_d = inner_q + 1'b1;
                end
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        case ({accept, push})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            total_q     <= '0;
            req_idx_q   <= '0;
            tile_q      <= '0;
            tile_e_q    <= '0;
            inner_q     <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
            outst_q     <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            req_idx_q   <= req_idx_d;
            tile_q      <= tile_d;
            tile_e_q    <= tile_e_d;
            inner_q     <= inner_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            outst_q     <= outst_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            zero_done_q <= zero_done_d;
        end
    end

    // Data storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.rsp_data_i;
    end

    a_rsp_without_request : assert property (@(posedge clk_i) disable iff (rst_i)
        !(bus.rsp_valid_i && (outst_q == '0)));
endmodule

// File: tb/tb_ita_tile_streamer.sv
module tb_ita_tile_streamer;
    localparam int BPT = 16;

    typedef struct {
        logic [31:0] addr;
        logic        first;
        logic        last;
        logic        fin;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  ts, tp, te;
    logic [31:0] base;
    logic        busy, done;

    int n_cmp = 0, n_bad = 0;
    int n_acc = 0, n_pop = 0, n_done = 0, job_gen = 0;
    logic [31:0] job_base = 32'h0;
    bit zero_exp = 1'b0;

    exp_t        sb[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    ita_tile_streamer_if #(.AddrW(32), .DataW(128)) bus ();

    ita_tile_streamer #(
        .M(8), .N(4), .DataW(128), .AddrW(32), .TileW(8), .FifoDepth(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .tile_s_i   (ts),
        .tile_p_i   (tp),
        .tile_e_i   (te),
        .base_addr_i(base),
        .busy_o     (busy),
        .done_o     (done),
        .bus        (bus)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [127:0] mdata(input logic [31:0] a);
        return {a ^ 32'hDEAD0000, ~a, a + 32'h11, a};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Inputs change at negedge+1, memory acts at +2, monitor samples at +3.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Memory: 2-cycle in-order read latency, checks request address sequence.
    initial begin
        int seen = 0;
        int rn = 0;
        int cn = 0;
        bus.rsp_valid_i = 1'b0;
        bus.rsp_data_i  = '0;
        forever begin
            @(negedge clk);
            #2;
            cn++;
            if (job_gen != seen) begin
                seen = job_gen;
                rn   = 0;
            end
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                bus.rsp_valid_i = 1'b0;
            end else begin
                if (bus.req_valid_o && bus.req_ready_i) begin
                    check("req_addr", 128'(bus.req_addr_o), 128'(job_base + 32'(rn * 16)));
                    rn++;
                    n_acc++;
                    pend_addr.push_back(bus.req_addr_o);
                    pend_due.push_back(cn + 2);
                end
                if (pend_due.size() > 0 && pend_due[0] <= cn) begin
                    bus.rsp_valid_i = 1'b1;
                    bus.rsp_data_i  = mdata(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    bus.rsp_valid_i = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (bus.oup_valid_o && bus.oup_ready_i) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_beat: actual=%0h required=none", bus.oup_data_o);
                    end else begin
                        e = sb.pop_front();
                        check("beat_data", bus.oup_data_o, mdata(e.addr));
                        check("first_flag", 128'(bus.first_inner_tile_o), 128'(e.first));
                        check("last_flag", 128'(bus.last_inner_tile_o), 128'(e.last));
                        check("done_on_pop", 128'(done), 128'(e.fin));
                    end
                    n_pop++;
                end else if (done || zero_exp) begin
                    check("done_idle", 128'(done), 128'(zero_exp));
                end
                if (done) n_done++;
            end
        end
    end

    task automatic start_job(input int s, input int p, input int e, input logic [31:0] b);
        int total;
        exp_t x;
        ts = 8'(s); tp = 8'(p); te = 8'(e); base = b;
        start = 1'b1;
        job_gen++;
        job_base = b;
        total = s * p * e * BPT;
        for (int k = 0; k < total; k++) begin
            x.addr  = b + 32'(k * 16);
            x.first = ((k / BPT) % e) == 0;
            x.last  = ((k / BPT) % e) == e - 1;
            x.fin   = (k == total - 1);
            sb.push_back(x);
        end
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = n_done;
        int t  = 0;
        while (n_done == d0 && t < budget) begin
            cyc(1);
            t++;
        end
        check("done_within_budget", 128'(t < budget), 128'(1));
        check("scoreboard_empty", 128'(sb.size()), 128'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_valid"}, 128'(bus.req_valid_o), 128'(0));
        check({tag, "_oup_valid"}, 128'(bus.oup_valid_o), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_first"}, 128'(bus.first_inner_tile_o), 128'(0));
        check({tag, "_last"}, 128'(bus.last_inner_tile_o), 128'(0));
    endtask

    initial begin
        int a0, p0, d0, t;
        logic [31:0] held;
        rst = 1'b1; start = 1'b0; ts = '0; tp = '0; te = '0; base = '0;
        bus.req_ready_i = 1'b1;
        bus.oup_ready_i = 1'b1;
        cyc(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        cyc(2);

        // Basic 1x1x1 job
        a0 = n_acc; d0 = n_done;
        start_job(1, 1, 1, 32'h1000);
        wait_done(400);
        cyc(3);
        check("job1_requests", 128'(n_acc - a0), 128'(16));
        check("job1_done_pulses", 128'(n_done - d0), 128'(1));
        check("job1_busy_after", 128'(busy), 128'(0));

        // 1x2x3 job with request stall, output backpressure, ignored start
        a0 = n_acc; p0 = n_pop; d0 = n_done;
        start_job(1, 2, 3, 32'h1000);
        cyc(8);
        t = 0;
        while (!bus.req_valid_o && t < 50) begin cyc(1); t++; end
        check("stall_valid_seen", 128'(bus.req_valid_o), 128'(1));
        bus.req_ready_i = 1'b0;
        held = bus.req_addr_o;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("stall_valid_held", 128'(bus.req_valid_o), 128'(1));
            check("stall_addr_held", 128'(bus.req_addr_o), 128'(held));
        end
        bus.req_ready_i = 1'b1;
        cyc(4);
        bus.oup_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (i == 5) begin
                ts = 8'd5; tp = 8'd5; te = 8'd7; base = 32'h9000; start = 1'b1;
            end
            if (i == 6) start = 1'b0;
            check("credit_bound", 128'((n_acc - n_pop) <= 4), 128'(1));
        end
        check("bp_req_valid_low", 128'(bus.req_valid_o), 128'(0));
        check("bp_inflight_full", 128'(n_acc - n_pop), 128'(4));
        check("bp_oup_valid", 128'(bus.oup_valid_o), 128'(1));
        bus.oup_ready_i = 1'b1;
        wait_done(2000);
        cyc(3);
        check("job2_requests", 128'(n_acc - a0), 128'(96));
        check("job2_beats", 128'(n_pop - p0), 128'(96));
        check("job2_done_pulses", 128'(n_done - d0), 128'(1));

        // Zero inner tiles: immediate done, no requests
        a0 = n_acc; d0 = n_done;
        start_job(1, 1, 0, 32'h1000);
        zero_exp = 1'b1;
        check("zero_busy", 128'(busy), 128'(0));
        cyc(1);
        zero_exp = 1'b0;
        cyc(5);
        check("zero_requests", 128'(n_acc - a0), 128'(0));
        check("zero_done_pulses", 128'(n_done - d0), 128'(1));

        // Mid-job reset after 7 beats, then restart from base
        p0 = n_pop;
        start_job(1, 1, 2, 32'h1000);
        t = 0;
        while ((n_pop - p0) < 7 && t < 300) begin cyc(1); t++; end
        check("midreset_reached_7", 128'((n_pop - p0) >= 7), 128'(1));
        rst = 1'b1;
        bus.oup_ready_i = 1'b0;
        bus.req_ready_i = 1'b0;
        cyc(1);
        rst = 1'b0;
        sb.delete();
        check_idle_outputs("midreset");
        bus.oup_ready_i = 1'b1;
        bus.req_ready_i = 1'b1;
        cyc(2);
        a0 = n_acc;
        start_job(1, 1, 1, 32'h1000);
        wait_done(400);
        check("restart_requests", 128'(n_acc - a0), 128'(16));

        cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/ita_tile_streamer.md
Name: ita_tile_streamer

Overview:
- Producer side of the ITA input/weight/bias valid/ready stream.
- Walks the tile order of a Linear (MatMul) step: outer tile, then inner tile, then beat.
- Issues sequential memory read requests and buffers in-order responses in a FIFO.
- Presents beats to the controller with oup_valid_o/oup_ready_i, tagging each beat with first/last inner-tile flags generated on the transmit side.

Parameters:
M, 64, tile edge; BeatsPerTile = M*M/N
N, 16, PE count / beat parallelism
DataW, 128, beat width in bits; BytesPerBeat = DataW/8
AddrW, 32, memory address width
TileW, 8, width of tile-count inputs
FifoDepth, 4, response FIFO entries; also the credit limit

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start pulse; sampled only in Idle
tile_s_i  in  TileW  sequence tiles
tile_p_i  in  TileW  projection tiles
tile_e_i  in  TileW  inner (embedding) tiles
base_addr_i  in  AddrW  byte address of beat 0
req_valid_o  out  1  read request valid
req_ready_i  in  1  memory accepts request
req_addr_o  out  AddrW  request byte address
rsp_valid_i  in  1  read data valid; in order, no backpressure
rsp_data_i  in  DataW  read data
oup_valid_o  out  1  beat valid to controller
oup_ready_i  in  1  controller ready
oup_data_o  out  DataW  beat data (FIFO head)
first_inner_tile_o  out  1  head beat belongs to inner tile 0
last_inner_tile_o  out  1  head beat belongs to inner tile tile_e-1
busy_o  out  1  high in Run or Drain
done_o  out  1  one-cycle pulse at end of job

Behaviour:
- Reset (rst_i high at a clock edge, including mid-job):
  - State goes to Idle; all counters, credits and FIFO are cleared.
  - req_valid_o, oup_valid_o, busy_o, done_o, first/last flags are all 0.
  - Responses in flight are discarded; the memory side must also be reset.
- Start:
  - In Idle, start_i latches tile_s/p/e and base_addr.
  - total = tile_s*tile_p*tile_e*BeatsPerTile.
  - If any tile count is 0: done_o pulses the next cycle and state stays Idle.
  - Otherwise the state goes to Run.
  - start_i outside Idle is ignored.
- States:
  - Idle -> Run on start.
  - Run -> Drain when the request with index total-1 is accepted.
  - Drain -> Idle when the last beat is popped; done_o pulses in that same cycle.
- Request side:
  - req_addr_o = base + req_idx*BytesPerBeat, with AddrW wrap-around (no saturation).
  - req_valid_o = (state==Run) && (outstanding + fifo_count < FifoDepth), using registered counts.
  - Once asserted, req_valid_o and req_addr_o stay stable until accepted.
  - On acceptance (req_valid_o && req_ready_i): req_idx++ and outstanding++.
- Response side:
  - rsp_valid_i pushes into the FIFO and decrements outstanding.
  - The credit rule guarantees the FIFO is never full on a push.
  - rsp_valid_i with outstanding==0 is a protocol error: data is dropped and a simulation assertion fires.
- Output side:
  - oup_valid_o = FIFO not empty. A pop happens when oup_valid_o && oup_ready_i.
  - A push and a pop in the same cycle leave fifo_count unchanged; the pushed data is visible at the head no earlier than the next cycle.
  - FIFO latency: rsp_valid_i at cycle t gives oup_valid_o at t+1.
  - The output counters (beat, inner, tile) advance on each pop:
    - beat wraps at BeatsPerTile and then increments inner;
    - inner wraps at tile_e and then increments tile.
  - first_inner_tile_o = oup_valid_o && (out_inner==0).
  - last_inner_tile_o = oup_valid_o && (out_inner==tile_e-1). Both flags are high when tile_e==1.
- Credit release:
  - A pop frees its credit on the following cycle.
  - An accept and a pop in the same cycle: outstanding+1 and fifo_count-1 both apply.
- Arithmetic: all counters are wide enough to hold total; beat counters are log2(BeatsPerTile) bits.

Test Plan:
All scenarios use M=8, N=4, BeatsPerTile=16, FifoDepth=4, base=0x1000, DataW=128.
- Basic job: tile s=p=e=1, memory with 2-cycle latency, oup_ready_i=1 -> exactly 16 requests at 0x1000..0x10F0 in steps of 0x10; 16 beats out in order; first and last flags high on all beats; one done_o pulse after the 16th pop.
- Inner-tile tagging: s=1, p=2, e=3 (96 beats) -> first flag on beats 0-15, 48-63; last flag on beats 32-47, 80-95; done_o after beat 95.
- Backpressure: oup_ready_i=0 for 20 cycles mid-job -> at most 4 requests outstanding plus buffered; no FIFO overflow; req_valid_o deasserts; resumes with no lost or duplicated beat.
- Request stall: req_ready_i low for 5 cycles -> req_addr_o held constant; no duplicate address issued.
- Zero tiles and ignored start: tile_e=0 -> done_o pulses one cycle after start, no requests; a start_i pulse during Run has no effect on count or addresses.
- Mid-job reset: rst_i asserted after 7 beats -> next cycle all outputs 0 and state Idle; a new start produces addresses beginning at base again.
